// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcodes, widths and the multiplier state type.
package exec_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_IDX_W = 5;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOT   = 4'b0101;
    localparam logic [3:0] OP_SHL   = 4'b0110;
    localparam logic [3:0] OP_SHR   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_MUL   = 4'b1001;
    localparam logic [3:0] OP_SLT   = 4'b1010;
    localparam logic [3:0] OP_MOVI  = 4'b1011;
    localparam logic [3:0] OP_LOAD  = 4'b1100;
    localparam logic [3:0] OP_NOP   = 4'b1101;
    localparam logic [3:0] OP_STORE = 4'b1110;
    localparam logic [3:0] OP_RSVD  = 4'b1111;

    localparam logic [3:0] OP_BUBBLE = OP_NOP;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_t;

    // STORE and NOP never write the register file.
    function automatic logic writes_reg(input logic [3:0] op);
        return !(op == OP_STORE || op == OP_NOP);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, W iterations per operation.
// state     | meaning
// MUL_IDLE  | waiting for i_start
// MUL_RUN   | accumulating; o_done flags the final iteration
module seq_multiplier
    import exec_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         i_clear,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_product
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    mul_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [W-1:0]     r_acc, r_mcand, r_mplier;
    logic [W-1:0]     w_acc_nxt, w_mcand_nxt, w_mplier_nxt, w_acc_step;

    assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        if (i_clear) begin
            w_state_nxt = MUL_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (i_start) begin
                        w_state_nxt  = MUL_RUN;
                        w_cnt_nxt    = '0;
                        w_acc_nxt    = '0;
                        w_mcand_nxt  = i_a;
                        w_mplier_nxt = i_b;
                    end
                end
                MUL_RUN: begin
                    w_acc_nxt    = w_acc_step;
                    w_mcand_nxt  = r_mcand << 1;
                    w_mplier_nxt = r_mplier >> 1;
                    w_cnt_nxt    = r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        w_state_nxt = MUL_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                default: w_state_nxt = MUL_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        r_state  <= w_state_nxt;
        r_cnt    <= w_cnt_nxt;
        r_acc    <= w_acc_nxt;
        r_mcand  <= w_mcand_nxt;
        r_mplier <= w_mplier_nxt;
    end

    assign o_busy    = (r_state == MUL_RUN);
    assign o_done    = o_busy && (r_cnt == LAST);
    // Valid only while o_done: includes the last partial product.
    assign o_product = w_acc_step;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU / address generation into the EX/MA register, with a stalling iterative multiply.
module execute_stage #(
    parameter int DATA_W    = exec_pkg::DATA_W,
    parameter int REG_IDX_W = exec_pkg::REG_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_id,
    input  logic [3:0]           control_id,
    input  logic [DATA_W-1:0]    operand_a_id,
    input  logic [DATA_W-1:0]    operand_b_id,
    input  logic [DATA_W-1:0]    reg_data_id,
    input  logic [REG_IDX_W-1:0] dest_reg_index_id,
    input  logic                 dest_reg_write_en_id,
    input  logic                 flush_ex,
    output logic                 stall_ex,
    output logic [3:0]           control_ex,
    output logic [DATA_W-1:0]    result_ex,
    output logic [DATA_W-1:0]    reg_data_ex,
    output logic [REG_IDX_W-1:0] dest_reg_index_ex,
    output logic                 dest_reg_write_en_ex
);
    import exec_pkg::*;

    logic                 w_clear, w_start, w_mul_busy, w_mul_done;
    logic [DATA_W-1:0]    w_product, w_alu;
    logic [3:0]           w_shamt;
    logic [3:0]           w_control_nxt;
    logic [DATA_W-1:0]    w_result_nxt, w_reg_data_nxt;
    logic [REG_IDX_W-1:0] w_idx_nxt;
    logic                 w_we_nxt;

    logic [3:0]           r_control;
    logic [DATA_W-1:0]    r_result, r_reg_data, r_mul_reg_data;
    logic [REG_IDX_W-1:0] r_idx, r_mul_idx;
    logic                 r_we, r_mul_we;

    assign w_clear  = !rst_n || flush_ex;
    assign w_start  = !w_clear && !w_mul_busy && valid_id && (control_id == OP_MUL);
    assign stall_ex = !w_clear && (w_start || (w_mul_busy && !w_mul_done));

    seq_multiplier #(.W(DATA_W)) u_mul (
        .clk       (clk),
        .i_clear   (w_clear),
        .i_start   (w_start),
        .i_a       (operand_a_id),
        .i_b       (operand_b_id),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    assign w_shamt = operand_b_id[3:0];

    always_comb begin
        w_alu = '0;
        case (control_id)
            OP_ADD:   w_alu = operand_a_id + operand_b_id;
            OP_SUB:   w_alu = operand_a_id - operand_b_id;
            OP_AND:   w_alu = operand_a_id & operand_b_id;
            OP_OR:    w_alu = operand_a_id | operand_b_id;
            OP_XOR:   w_alu = operand_a_id ^ operand_b_id;
            OP_NOT:   w_alu = ~operand_a_id;
            OP_SHL:   w_alu = operand_a_id << w_shamt;
            OP_SHR:   w_alu = operand_a_id >> w_shamt;
            OP_SRA:   w_alu = $signed(operand_a_id) >>> w_shamt;
            OP_SLT:   w_alu = {{(DATA_W-1){1'b0}}, ($signed(operand_a_id) < $signed(operand_b_id))};
            OP_MOVI:  w_alu = operand_b_id;
            OP_LOAD,
            OP_STORE: w_alu = operand_a_id + operand_b_id;
            default:  w_alu = '0;
        endcase
    end

    // Priority: reset/flush, finishing multiply, multiply in flight, then fresh instruction.
    always_comb begin
        w_control_nxt  = OP_BUBBLE;
        w_result_nxt   = '0;
        w_reg_data_nxt = '0;
        w_idx_nxt      = '0;
        w_we_nxt       = 1'b0;
        if (w_clear) begin
            w_control_nxt = OP_BUBBLE;
        end else if (w_mul_done) begin
            w_control_nxt  = OP_MUL;
            w_result_nxt   = w_product;
            w_reg_data_nxt = r_mul_reg_data;
            w_idx_nxt      = r_mul_idx;
            w_we_nxt       = r_mul_we;
        end else if (!w_mul_busy && valid_id && control_id != OP_MUL && control_id != OP_RSVD) begin
            w_control_nxt  = control_id;
            w_result_nxt   = w_alu;
            w_reg_data_nxt = reg_data_id;
            w_idx_nxt      = dest_reg_index_id;
            w_we_nxt       = dest_reg_write_en_id && writes_reg(control_id);
        end
    end

    always_ff @(posedge clk) begin
        r_control  <= w_control_nxt;
        r_result   <= w_result_nxt;
        r_reg_data <= w_reg_data_nxt;
        r_idx      <= w_idx_nxt;
        r_we       <= w_we_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_start) begin
            r_mul_reg_data <= reg_data_id;
            r_mul_idx      <= dest_reg_index_id;
            r_mul_we       <= dest_reg_write_en_id;
        end
    end

    assign control_ex           = r_control;
    assign result_ex            = r_result;
    assign reg_data_ex          = r_reg_data;
    assign dest_reg_index_ex    = r_idx;
    assign dest_reg_write_en_ex = r_we;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push expectations, a monitor checks outputs.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_id;
    logic [3:0]  control_id;
    logic [15:0] operand_a_id, operand_b_id, reg_data_id;
    logic [4:0]  dest_reg_index_id;
    logic        dest_reg_write_en_id;
    logic        flush_ex;
    logic        stall_ex;
    logic [3:0]  control_ex;
    logic [15:0] result_ex, reg_data_ex;
    logic [4:0]  dest_reg_index_ex;
    logic        dest_reg_write_en_ex;

    typedef struct {
        int          cyc;
        logic [3:0]  op;
        logic [15:0] res;
        logic [15:0] rd;
        logic [4:0]  idx;
        logic        we;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 0;

    execute_stage dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .valid_id             (valid_id),
        .control_id           (control_id),
        .operand_a_id         (operand_a_id),
        .operand_b_id         (operand_b_id),
        .reg_data_id          (reg_data_id),
        .dest_reg_index_id    (dest_reg_index_id),
        .dest_reg_write_en_id (dest_reg_write_en_id),
        .flush_ex             (flush_ex),
        .stall_ex             (stall_ex),
        .control_ex           (control_ex),
        .result_ex            (result_ex),
        .reg_data_ex          (reg_data_ex),
        .dest_reg_index_ex    (dest_reg_index_ex),
        .dest_reg_write_en_ex (dest_reg_write_en_ex)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] rd, input logic [4:0] idx, input logic we);
        valid_id             = 1'b1;
        control_id           = op;
        operand_a_id         = a;
        operand_b_id         = b;
        reg_data_id          = rd;
        dest_reg_index_id    = idx;
        dest_reg_write_en_id = we;
    endtask

    task automatic push(input int c, input logic [3:0] op, input logic [15:0] res,
                        input logic [15:0] rd, input logic [4:0] idx, input logic we);
        exp_t e;
        e.cyc = c; e.op = op; e.res = res; e.rd = rd; e.idx = idx; e.we = we;
        q.push_back(e);
    endtask

    task automatic alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] rd, input logic [4:0] idx, input logic we,
                       input logic [15:0] er, input logic ewe, input bit expect_out);
        @(negedge clk);
        drive(op, a, b, rd, idx, we);
        #1 chk("stall_alu", 64'(stall_ex), 64'd0);
        if (expect_out) push(cyc + 1, op, er, rd, idx, ewe);
    endtask

    // Holds MUL inputs for the whole run but presents a decoy ADD mid-run to prove inputs are ignored.
    task automatic mul(input logic [15:0] a, input logic [15:0] b, input logic [4:0] idx,
                       input logic [15:0] er);
        @(negedge clk);
        drive(4'b1001, a, b, 16'h0000, idx, 1'b1);
        push(cyc + 17, 4'b1001, er, 16'h0000, idx, 1'b1);
        for (int k = 0; k <= 16; k++) begin
            #1 chk($sformatf("stall_mul_k%0d", k), 64'(stall_ex), (k < 16) ? 64'd1 : 64'd0);
            if (k < 16) begin
                @(negedge clk);
                if (k == 1) drive(4'b0000, 16'h5555, 16'h1111, 16'hAAAA, 5'd30, 1'b1);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (control_ex !== 4'b1101) begin
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL out_unexpected actual op=%h res=%h required=no output (cycle %0d)",
                                 control_ex, result_ex, cyc);
                    end else begin
                        e = q.pop_front();
                        if (cyc != e.cyc || control_ex !== e.op || result_ex !== e.res ||
                            reg_data_ex !== e.rd || dest_reg_index_ex !== e.idx ||
                            dest_reg_write_en_ex !== e.we) begin
                            failures++;
                            $display("FAIL out_%h actual cyc=%0d op=%h res=%h rd=%h idx=%0d we=%b required cyc=%0d op=%h res=%h rd=%h idx=%0d we=%b",
                                     e.op, cyc, control_ex, result_ex, reg_data_ex, dest_reg_index_ex,
                                     dest_reg_write_en_ex, e.cyc, e.op, e.res, e.rd, e.idx, e.we);
                        end
                    end
                end else begin
                    chk("bubble_fields", {26'd0, result_ex, reg_data_ex, dest_reg_index_ex,
                                          dest_reg_write_en_ex}, 64'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int t;
        rst_n = 1'b0;
        flush_ex = 1'b0;
        drive(4'b1001, 16'h0003, 16'h0003, 16'h0000, 5'd1, 1'b1);
        repeat (3) @(negedge clk);
        #1 chk("stall_in_reset", 64'(stall_ex), 64'd0);
        chk("reset_control", 64'(control_ex), 64'hD);
        chk("reset_we", 64'(dest_reg_write_en_ex), 64'd0);
        mon_en = 1;
        @(negedge clk);
        rst_n = 1'b1;
        valid_id = 1'b0;

        alu(4'b0000, 16'h7FFF, 16'h0001, 16'h0000, 5'd3, 1'b1, 16'h8000, 1'b1, 1);
        alu(4'b0001, 16'h0000, 16'h0001, 16'h0000, 5'd4, 1'b1, 16'hFFFF, 1'b1, 1);
        alu(4'b0010, 16'hF0F0, 16'h3C3C, 16'h0000, 5'd5, 1'b0, 16'h3030, 1'b0, 1);
        alu(4'b0011, 16'hF0F0, 16'h0F0F, 16'h0000, 5'd6, 1'b1, 16'hFFFF, 1'b1, 1);
        alu(4'b0100, 16'hFF00, 16'h0FF0, 16'h0000, 5'd7, 1'b1, 16'hF0F0, 1'b1, 1);
        alu(4'b0101, 16'h1234, 16'h0000, 16'h0000, 5'd8, 1'b1, 16'hEDCB, 1'b1, 1);
        alu(4'b0110, 16'h0001, 16'h0013, 16'h0000, 5'd9, 1'b1, 16'h0008, 1'b1, 1);
        alu(4'b1000, 16'h8000, 16'h0004, 16'h0000, 5'd10, 1'b1, 16'hF800, 1'b1, 1);
        alu(4'b0111, 16'h8000, 16'h0004, 16'h0000, 5'd11, 1'b1, 16'h0800, 1'b1, 1);
        alu(4'b1010, 16'hFFFF, 16'h0001, 16'h0000, 5'd12, 1'b1, 16'h0001, 1'b1, 1);
        alu(4'b1010, 16'h0001, 16'hFFFF, 16'h0000, 5'd13, 1'b1, 16'h0000, 1'b1, 1);
        alu(4'b1011, 16'h9999, 16'hABCD, 16'h0000, 5'd14, 1'b1, 16'hABCD, 1'b1, 1);
        alu(4'b1110, 16'h1000, 16'h0004, 16'hBEEF, 5'd15, 1'b1, 16'h1004, 1'b0, 1);
        alu(4'b1100, 16'h1000, 16'h0004, 16'h0000, 5'd16, 1'b1, 16'h1004, 1'b1, 1);
        alu(4'b1111, 16'h1234, 16'h5678, 16'h9ABC, 5'd17, 1'b1, 16'h0000, 1'b0, 0);

        mul(16'h0123, 16'h0010, 5'd18, 16'h1230);
        mul(16'hFFFF, 16'hFFFF, 5'd19, 16'h0001);
        @(negedge clk);
        valid_id = 1'b0;

        // Flush five cycles into a multiply.
        @(negedge clk);
        drive(4'b1001, 16'h0003, 16'h0004, 16'h0000, 5'd20, 1'b1);
        t = cyc;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1 chk("stall_pre_flush", 64'(stall_ex), 64'd1);
        end
        @(negedge clk);
        flush_ex = 1'b1;
        #1 chk("stall_during_flush", 64'(stall_ex), 64'd0);
        chk("flush_cycle", 64'(cyc - t), 64'd5);
        @(negedge clk);
        flush_ex = 1'b0;
        chk("flush_bubble_op", 64'(control_ex), 64'hD);
        alu_now(4'b0000, 16'h0002, 16'h0003, 5'd21, 16'h0005);
        @(negedge clk);
        valid_id = 1'b0;

        // Reset eight cycles into a multiply.
        @(negedge clk);
        drive(4'b1001, 16'h0101, 16'h0002, 16'h0000, 5'd22, 1'b1);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1 chk("stall_mid_reset", 64'(stall_ex), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        valid_id = 1'b0;
        chk("reset_bubble_op", 64'(control_ex), 64'hD);
        chk("reset_bubble_res", 64'(result_ex), 64'd0);
        #1 chk("stall_after_reset", 64'(stall_ex), 64'd0);
        alu(4'b0000, 16'h1111, 16'h2222, 16'h0000, 5'd23, 1'b1, 16'h3333, 1'b1, 1);

        // MUL presented together with flush must not start.
        @(negedge clk);
        drive(4'b1001, 16'h0007, 16'h0007, 16'h0000, 5'd24, 1'b1);
        flush_ex = 1'b1;
        #1 chk("stall_flush_mul", 64'(stall_ex), 64'd0);
        @(negedge clk);
        flush_ex = 1'b0;
        valid_id = 1'b0;
        #1 chk("stall_no_mul_started", 64'(stall_ex), 64'd0);

        repeat (20) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic alu_now(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [4:0] idx, input logic [15:0] er);
        drive(op, a, b, 16'h0000, idx, 1'b1);
        #1 chk("stall_post_flush", 64'(stall_ex), 64'd0);
        push(cyc + 1, op, er, 16'h0000, idx, 1'b1);
    endtask

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 16-bit pipelined core. Sits between decode and the memory-access stage.
- Performs ALU operations and load/store address generation, then registers the result into the EX/MA pipeline register that feeds memory access.
- Includes an iterative 16-cycle multiplier that stalls the upstream stages while it runs.
- Handles pipeline flush (branch redirect) and inserts bubbles.

Parameters:
- DATA_W, 16, datapath width; multiplier iterations equal DATA_W.
- REG_IDX_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous reset, active-low.
- valid_id  in  1  decode presents a valid instruction.
- control_id  in  4  opcode.
- operand_a_id  in  16  first ALU operand (base for LOAD/STORE).
- operand_b_id  in  16  second operand (offset for LOAD/STORE).
- reg_data_id  in  16  store data.
- dest_reg_index_id  in  5  destination register index.
- dest_reg_write_en_id  in  1  destination write enable.
- flush_ex  in  1  kill the instruction currently in EX.
- stall_ex  out  1  combinational; upstream holds its outputs when high.
- control_ex  out  4  registered opcode to memory access.
- result_ex  out  16  registered ALU result or memory address.
- reg_data_ex  out  16  registered store data.
- dest_reg_index_ex  out  5  registered destination index.
- dest_reg_write_en_ex  out  1  registered write enable.

Behaviour:
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 NOT(a).
  - 0110 SHL a by b[3:0]; 0111 SHR logical; 1000 SRA.
  - 1001 MUL: low 16 bits of the product.
  - 1010 SLT: signed, result 1 or 0.
  - 1011 MOVI: result = b.
  - 1100 LOAD and 1110 STORE: result = a+b.
  - 1101 NOP; 1111 reserved.
- Arithmetic wraps modulo 2^16; no flags.
- Bubble = control_ex 1101, dest_reg_write_en_ex 0, other outputs 0.
- Write-enable rules: dest_reg_write_en_ex is forced 0 for STORE and NOP. Reserved 1111 is converted to a bubble. All other opcodes pass dest_reg_write_en_id through.
- Reset: when rst_n is low at posedge, all outputs take bubble values, the FSM goes to IDLE, the counter clears, and stall_ex reads 0 while rst_n is low. A reset mid-MUL aborts it.
- FSM states: IDLE and MUL_RUN, with a 4-bit iteration counter.
- IDLE, non-MUL:
  - valid_id high in cycle T: outputs are updated at the end of T and visible in T+1 (1-cycle latency).
  - valid_id low: bubble.
- IDLE, MUL with valid_id high in cycle T:
  - stall_ex is high in T.
  - At end of T: latch the operands and instruction fields, counter=0, go to MUL_RUN, and the output register loads a bubble.
- MUL_RUN (cycles T+1..T+16):
  - One shift-add iteration per edge, counter++.
  - stall_ex is high while counter != 15 and low in the final cycle (T+16), so upstream advances at the end of T+16.
  - Inputs are ignored throughout MUL_RUN.
  - Outputs are bubbles in T+1..T+16.
  - At end of T+16 the product is registered and the FSM returns to IDLE. The result is visible in T+17.
- flush_ex, evaluated after reset:
  - Flush has highest priority.
  - At the edge, outputs load a bubble, the FSM goes to IDLE and the counter clears. This applies in IDLE and in MUL_RUN.
  - stall_ex = 0 in any cycle where flush_ex is high.
- Simultaneous flush_ex with a valid MUL in IDLE: the MUL is not started.
- Back-to-back MULs: the second MUL is accepted in T+17 and runs a full 16 iterations.

Decomposition:
- Package exec_pkg holds:
  - opcode localparams (LOAD 4'b1100 and STORE 4'b1110 shared with memory access);
  - the bubble opcode;
  - DATA_W.
- Sub-module seq_multiplier:
  - ports: start, a, b, busy, done, product;
  - 16-iteration shift-add;
  - clear input driven by flush or reset.

Test Plan:
- ADD a=0x7FFF b=0x0001, valid in T -> T+1: result_ex 0x8000, control_ex 0000, write_en follows input; stall_ex stays 0.
- MUL a=0x0123 b=0x0010 in T -> stall_ex high T..T+15, low T+16; bubbles T+1..T+16; T+17 result_ex 0x1230. Then MUL 0xFFFF*0xFFFF -> 0x0001.
- STORE a=0x1000 b=0x0004 reg_data=0xBEEF, write_en_id=1 -> result_ex 0x1004, reg_data_ex 0xBEEF, dest_reg_write_en_ex 0. LOAD with the same operands -> 0x1004, write_en 1.
- SRA 0x8000 by 4 -> 0xF800; SHR 0x8000 by 4 -> 0x0800; SLT a=0xFFFF b=0x0001 -> 0x0001; opcode 1111 -> bubble.
- MUL started in T, flush_ex high in T+5 -> T+6 bubble with stall_ex 0; an ADD presented in T+6 appears on outputs in T+7.
- rst_n low in T+8 mid-MUL -> T+9 outputs are bubble/zero, stall_ex 0; after release a new ADD completes with 1-cycle latency.
